// File: rtl/jtag_pkg.sv
// Shared JTAG types: command encodings, master FSM states, TAP states.
// The tap_next helper mirrors the IEEE 1149.1 TAP transition diagram.
package jtag_pkg;

  localparam int RESET_TMS_CYCLES = 5;

  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_IR    = 2'd1,
    CMD_DR    = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_type_e;

  typedef enum logic [3:0] {
    RST_SEQ,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    RESP
  } mst_state_e;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EX1_DR,
    TAP_PAUSE_DR,
    TAP_EX2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EX1_IR,
    TAP_PAUSE_IR,
    TAP_EX2_IR,
    TAP_UPD_IR
  } tap_state_e;

  function automatic tap_state_e tap_next(
    tap_state_e s,
    logic       tms
  );
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   n = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   n = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   n = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   n = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_master_if.sv
// Command/response handshake bundle between a sequencer and jtag_master.
// The master modport is the requester, slave is the JTAG controller.
interface jtag_master_if #(
  parameter int DR_W  = 51,
  parameter int LEN_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_type;
  logic [LEN_W-1:0] cmd_len;
  logic [DR_W-1:0]  cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DR_W-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_type, cmd_len,
    output cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len,
    input  cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: half-period of CLK_DIV clocks, idles low when disabled.
// rise_o/fall_o flag the clock in which TCK is about to toggle.
module jtag_tck_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    tck_d = wrap ? ~tck_q : tck_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = en_i && wrap && !tck_q;
  assign fall_o = en_i && wrap && tck_q;
endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG master: runs TAP reset, IR and DR scans from a
// command handshake and returns the captured TDO bits.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int N       = 16,
  parameter int IR_W    = 2,
  parameter int DR_W    = 3 * N + 3,
  parameter int CLK_DIV = 3
) (
  input  logic         CLK,
  input  logic         RST,
  jtag_master_if.slave bus,
  output logic         TCK,
  output logic         TMS,
  output logic         TDI,
  input  logic         TDO
);
  localparam int LEN_W = $clog2(DR_W + 1);

  mst_state_e       state_q, state_d;
  tap_state_e       tap_q, tap_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] len_q, len_d, len_c;
  logic [DR_W-1:0]  data_q, data_d;
  logic [DR_W-1:0]  rsp_q, rsp_d;
  logic             ir_q, ir_d;
  logic             boot_q, boot_d;
  logic             tck_en, rise, fall;
  logic             in_shift;
  logic             cmd_ready, rsp_valid;

  assign tck_en = (state_q != IDLE) &&
                  (state_q != RESP);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (tck_en),
    .tck_o  (TCK),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign in_shift = (tap_q == TAP_SHIFT_DR) ||
                    (tap_q == TAP_SHIFT_IR);

  assign len_c =
    (bus.cmd_type == CMD_IR)
      ? ((bus.cmd_len > LEN_W'(IR_W))
          ? LEN_W'(IR_W) : bus.cmd_len)
      : ((bus.cmd_len > LEN_W'(DR_W))
          ? LEN_W'(DR_W) : bus.cmd_len);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RST_SEQ;
      tap_q   <= TAP_TLR;
      cnt_q   <= '0;
      k_q     <= '0;
      len_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      ir_q    <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      ir_q    <= ir_d;
      boot_q  <= boot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = rise ? tap_next(tap_q, TMS) : tap_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    len_d   = len_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    ir_d    = ir_q;
    boot_d  = boot_q;
    if (rise && in_shift) rsp_d[k_q] = TDO;
    unique case (state_q)
      RST_SEQ: if (fall) begin
        if (cnt_q == 3'(RESET_TMS_CYCLES)) begin
          cnt_d   = '0;
          boot_d  = 1'b0;
          state_d = boot_q ? IDLE : RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      IDLE: if (bus.cmd_valid) begin
        ir_d   = (bus.cmd_type == CMD_IR);
        len_d  = len_c;
        data_d = bus.cmd_data;
        rsp_d  = '0;
        cnt_d  = '0;
        k_d    = '0;
        if (bus.cmd_type == CMD_RESET)
          state_d = RST_SEQ;
        else if (bus.cmd_type != CMD_RSVD &&
                 len_c != '0)
          state_d = SEL_DR;
        else
          state_d = RESP;
      end
      SEL_DR: if (fall)
        state_d = ir_q ? SEL_IR : CAPTURE;
      SEL_IR: if (fall) state_d = CAPTURE;
      // two TMS=0 cycles: into Capture, then into Shift
      CAPTURE: if (fall) begin
        if (cnt_q == '0) begin
          cnt_d = 3'd1;
        end else begin
          cnt_d   = '0;
          state_d = (len_q == LEN_W'(1))
                    ? EXIT1 : SHIFT;
        end
      end
      SHIFT: if (fall) begin
        data_d = data_q >> 1;
        k_d    = k_q + LEN_W'(1);
        if (k_q == len_q - LEN_W'(2))
          state_d = EXIT1;
      end
      EXIT1: if (fall) state_d = UPDATE;
      UPDATE: if (fall) begin
        if (cnt_q == '0) begin
          cnt_d = 3'd1;
        end else begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = RST_SEQ;
    endcase
  end

  always_comb begin
    TMS       = 1'b0;
    TDI       = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      RST_SEQ: TMS = (cnt_q != 3'(RESET_TMS_CYCLES));
      IDLE:    cmd_ready = 1'b1;
      SEL_DR:  TMS = 1'b1;
      SEL_IR:  TMS = 1'b1;
      SHIFT:   TDI = data_q[0];
      EXIT1: begin
        TMS = 1'b1;
        TDI = data_q[0];
      end
      UPDATE:  TMS = (cnt_q == '0);
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_q;
endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master with a loopback TDO and a small TAP.
// Expected TMS/TDI streams and responses are hand-computed constants.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int DR_W  = 51;
  localparam int LEN_W = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TCK, TMS, TDI, TDO;

  always #5 CLK = ~CLK;

  jtag_master_if #(.DR_W(DR_W), .LEN_W(LEN_W)) bus ();

  jtag_master #(
    .N(16), .IR_W(2), .CLK_DIV(3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .TCK (TCK),
    .TMS (TMS),
    .TDI (TDI),
    .TDO (TDO)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          pulses = 0;
  int          base   = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] tdi_log = '0;
  logic        lb      = 1'b0;
  logic        use_tap = 1'b0;

  always @(posedge TCK) begin
    pulses  <= pulses + 1;
    tms_log <= {tms_log[62:0], TMS};
    tdi_log <= {tdi_log[62:0], TDI};
    lb      <= TDI;
  end

  function automatic tap_state_e tb_next(
    tap_state_e s, logic m
  );
    case (s)
      TAP_TLR:      return m ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      return m ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   return m ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   return m ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return m ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   return m ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return m ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   return m ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   return m ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   return m ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   return m ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return m ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   return m ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return m ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   return m ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   return m ? TAP_SEL_DR : TAP_RTI;
      default:      return TAP_TLR;
    endcase
  endfunction

  // target TAP: 2-bit IR, captures 2'b01, TDO changes on TCK fall
  tap_state_e t_q = TAP_TLR;
  logic [1:0] ir_sr = 2'b00;
  logic [1:0] ir_r  = 2'b00;
  logic       tdo_t = 1'b0;

  always @(posedge TCK) begin
    if (t_q == TAP_CAP_IR)   ir_sr <= 2'b01;
    if (t_q == TAP_SHIFT_IR) ir_sr <= {TDI, ir_sr[1]};
    if (t_q == TAP_UPD_IR)   ir_r  <= ir_sr;
    t_q <= tb_next(t_q, TMS);
  end

  always @(negedge TCK) tdo_t <= ir_sr[0];

  assign TDO = use_tap ? tdo_t : lb;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(
    input logic [1:0]      t,
    input logic [5:0]      len,
    input logic [DR_W-1:0] d
  );
    bus.cmd_type  = t;
    bus.cmd_len   = len;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    base = pulses;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  int   n;
  logic ok;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    RST = 1'b1;
    tick();
    tick();
    check("rst_tck", 64'(TCK), 64'd0);
    check("rst_tms", 64'(TMS), 64'd1);
    check("rst_tdi", 64'(TDI), 64'd0);
    check("rst_rdy", 64'(bus.cmd_ready), 64'd0);
    check("rst_vld", 64'(bus.rsp_valid), 64'd0);
    check("rst_data", 64'(bus.rsp_data), 64'd0);

    base = pulses;
    RST  = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("boot_cycles", 64'(n), 64'd36);
    check("boot_pulses", 64'(pulses - base), 64'd6);
    check("boot_tms", 64'(tms_log[5:0]), 64'b111110);
    check("boot_tdi", 64'(tdi_log[5:0]), 64'd0);
    check("boot_tap", 64'(t_q), 64'(TAP_RTI));

    use_tap = 1'b0;
    send(CMD_DR, 6'd51, 51'h5555555555555);
    check("dr_rdy_drop", 64'(bus.cmd_ready), 64'd0);
    wait_rsp(n);
    check("dr_lat", 64'(n), 64'd336);
    check("dr_pulses", 64'(pulses - base), 64'd56);
    check("dr_data", 64'(bus.rsp_data),
          64'h2AAAAAAAAAAAA);
    check("dr_tck_low", 64'(TCK), 64'd0);
    ack();
    check("dr_rdy_back", 64'(bus.cmd_ready), 64'd1);

    use_tap = 1'b1;
    send(CMD_IR, 6'd2, 51'b10);
    wait_rsp(n);
    check("ir_lat", 64'(n), 64'd48);
    check("ir_pulses", 64'(pulses - base), 64'd8);
    check("ir_tms", 64'(tms_log[7:0]), 64'b11000110);
    check("ir_tdi", 64'(tdi_log[7:0]), 64'b00000100);
    check("ir_data", 64'(bus.rsp_data), 64'd1);
    check("ir_reg", 64'(ir_r), 64'b10);
    check("ir_tap", 64'(t_q), 64'(TAP_RTI));
    ack();

    send(CMD_IR, 6'd5, 51'b11101);
    wait_rsp(n);
    check("irc_pulses", 64'(pulses - base), 64'd8);
    check("irc_data", 64'(bus.rsp_data), 64'd1);
    check("irc_reg", 64'(ir_r), 64'b01);
    ack();

    send(2'd3, 6'd10, 51'h3FF);
    wait_rsp(n);
    check("rsv_lat", 64'(n), 64'd0);
    check("rsv_pulses", 64'(pulses - base), 64'd0);
    check("rsv_data", 64'(bus.rsp_data), 64'd0);
    ack();

    use_tap = 1'b0;
    send(CMD_DR, 6'd8, 51'hA5);
    wait_rsp(n);
    check("bp_data", 64'(bus.rsp_data), 64'h4A);
    bus.cmd_type  = CMD_DR;
    bus.cmd_len   = 6'd0;
    bus.cmd_data  = 51'h1F;
    bus.cmd_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.rsp_valid || bus.cmd_ready ||
          bus.rsp_data != 51'h4A) ok = 1'b0;
    end
    check("bp_hold", 64'(ok), 64'd1);
    ack();
    check("bp_rdy", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    base = pulses;
    check("bp2_rdy", 64'(bus.cmd_ready), 64'd0);
    wait_rsp(n);
    check("len0_lat", 64'(n), 64'd0);
    check("len0_data", 64'(bus.rsp_data), 64'd0);
    check("len0_pulses", 64'(pulses - base), 64'd0);
    ack();

    send(CMD_DR, 6'd51, 51'h7FFFFFFFFFFFF);
    n = 0;
    while ((pulses - base) < 24 && n < 1000) begin
      tick();
      n++;
    end
    check("mid_reach", 64'(pulses - base), 64'd24);
    RST = 1'b1;
    tick();
    check("mid_tck", 64'(TCK), 64'd0);
    check("mid_vld", 64'(bus.rsp_valid), 64'd0);
    RST  = 1'b0;
    base = pulses;
    ok   = 1'b0;
    n    = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
      if (bus.rsp_valid) ok = 1'b1;
    end
    check("mid_cycles", 64'(n), 64'd36);
    check("mid_pulses", 64'(pulses - base), 64'd6);
    check("mid_tms", 64'(tms_log[5:0]), 64'b111110);
    check("mid_no_rsp", 64'(ok), 64'd0);
    check("mid_tap", 64'(t_q), 64'(TAP_RTI));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
